// File: rtl/ber_pkg.sv
// Shared types, widths and helpers for the BER measurement controller.
package ber_pkg;

    localparam int LFSR_WIDTH    = 22;
    localparam int SYM_WIDTH     = 2;
    localparam int SYM_CNT_WIDTH = LFSR_WIDTH;
    localparam int BIT_CNT_WIDTH = 24;
    localparam logic [LFSR_WIDTH-1:0] LFSR_PERIOD = 22'h3FFFFF;

    typedef logic [2:0] ber_state_t;

    localparam ber_state_t ST_IDLE    = 3'd0;
    localparam ber_state_t ST_LOAD    = 3'd1;
    localparam ber_state_t ST_FLUSH   = 3'd2;
    localparam ber_state_t ST_MEASURE = 3'd3;
    localparam ber_state_t ST_DONE    = 3'd4;

    // Number of set bits in a 4-bit I/Q mismatch vector, built from two 2-bit halves.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [1:0] hi;
        logic [1:0] lo;
        hi = {1'b0, v[3]} + {1'b0, v[2]};
        lo = {1'b0, v[1]} + {1'b0, v[0]};
        return {1'b0, hi} + {1'b0, lo};
    endfunction

endpackage

// File: rtl/sym_delay_line.sv
// Enable-gated symbol shift register; DEPTH of zero gives a straight passthrough.
module sym_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= '0;
                    end
                end else if (en) begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ber_test_ctrl.sv
// Sequences one BER run: LFSR load, pipeline flush, then symbol/bit error accumulation.
module ber_test_ctrl
    import ber_pkg::*;
#(
    parameter int unsigned N_SYMBOLS     = LFSR_PERIOD,
    parameter int unsigned DELAY         = 4,
    parameter int unsigned FLUSH_SAMPLES = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sam_clk_ena,
    input  logic                     start,
    input  logic                     abort,
    input  logic [SYM_WIDTH-1:0]     ref_i_sym,
    input  logic [SYM_WIDTH-1:0]     ref_q_sym,
    input  logic [SYM_WIDTH-1:0]     rx_i_sym,
    input  logic [SYM_WIDTH-1:0]     rx_q_sym,
    output logic                     load_data,
    output logic                     busy,
    output logic                     done,
    output logic [SYM_CNT_WIDTH-1:0] sym_count,
    output logic [SYM_CNT_WIDTH-1:0] sym_err_count,
    output logic [BIT_CNT_WIDTH-1:0] bit_err_count
);

    localparam int FW = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;
    localparam logic [FW-1:0]            FLUSH_LAST = FW'(FLUSH_SAMPLES - 1);
    localparam logic [SYM_CNT_WIDTH-1:0] SYM_LAST   = SYM_CNT_WIDTH'(N_SYMBOLS - 1);

    ber_state_t                 state_q, state_d;
    logic [FW-1:0]              flush_cnt_q;
    logic [2*SYM_WIDTH-1:0]     ref_dly;
    logic [2*SYM_WIDTH-1:0]     mismatch;
    logic [2:0]                 bit_errs;
    logic [BIT_CNT_WIDTH:0]     bit_sum;
    logic                       dly_en;

    assign dly_en   = sam_clk_ena && (state_q != ST_LOAD);
    assign mismatch = {rx_i_sym, rx_q_sym} ^ ref_dly;
    assign bit_errs = popcount4(mismatch);
    assign bit_sum  = {1'b0, bit_err_count} + {{(BIT_CNT_WIDTH - 2){1'b0}}, bit_errs};

    sym_delay_line #(
        .DEPTH (DELAY),
        .WIDTH (2 * SYM_WIDTH)
    ) u_ref_dly (
        .clk   (clk),
        .reset (reset),
        .en    (dly_en),
        .din   ({ref_i_sym, ref_q_sym}),
        .dout  (ref_dly)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start && !abort) state_d = ST_LOAD;
            ST_LOAD:    state_d = abort ? ST_IDLE : ST_FLUSH;
            ST_FLUSH: begin
                if (abort) state_d = ST_IDLE;
                else if (sam_clk_ena && flush_cnt_q == FLUSH_LAST) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (abort) state_d = ST_IDLE;
                else if (sam_clk_ena && sym_count == SYM_LAST) state_d = ST_DONE;
            end
            ST_DONE:    if (start && !abort) state_d = ST_LOAD;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they align with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            load_data <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_data <= (state_d == ST_LOAD);
            busy      <= (state_d == ST_LOAD) || (state_d == ST_FLUSH) ||
                         (state_d == ST_MEASURE);
            done      <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt_q   <= '0;
            sym_count     <= '0;
            sym_err_count <= '0;
            bit_err_count <= '0;
        end else if (state_d == ST_LOAD) begin
            flush_cnt_q   <= '0;
            sym_count     <= '0;
            sym_err_count <= '0;
            bit_err_count <= '0;
        end else if (state_q == ST_FLUSH && sam_clk_ena && !abort) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
        end else if (state_q == ST_MEASURE && sam_clk_ena && !abort) begin
            if (sym_count != '1) sym_count <= sym_count + 1'b1;
            if (mismatch != '0 && sym_err_count != '1) sym_err_count <= sym_err_count + 1'b1;
            bit_err_count <= bit_sum[BIT_CNT_WIDTH] ? '1 : bit_sum[BIT_CNT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Directed bench for ber_test_ctrl with a short run length and an in-bench reference history.
module tb_ber_test_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sam_clk_ena;
    logic        start;
    logic        abort;
    logic [1:0]  ref_i_sym, ref_q_sym, rx_i_sym, rx_q_sym;
    logic        load_data, busy, done;
    logic [21:0] sym_count, sym_err_count;
    logic [23:0] bit_err_count;

    int          nvec = 0;
    int          nerr = 0;
    int          sidx = 0;
    logic [3:0]  d1, d2;

    ber_test_ctrl #(
        .N_SYMBOLS     (16),
        .DELAY         (2),
        .FLUSH_SAMPLES (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sam_clk_ena   (sam_clk_ena),
        .start         (start),
        .abort         (abort),
        .ref_i_sym     (ref_i_sym),
        .ref_q_sym     (ref_q_sym),
        .rx_i_sym      (rx_i_sym),
        .rx_q_sym      (rx_q_sym),
        .load_data     (load_data),
        .busy          (busy),
        .done          (done),
        .sym_count     (sym_count),
        .sym_err_count (sym_err_count),
        .bit_err_count (bit_err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One strobe; mode 0 loopback, 1 flips I bit0, 2 inverts all bits. Ends 4 clk later at #1.
    task automatic strobe(input int mode);
        logic [3:0] refv, rxv;
        refv = 4'((sidx * 5 + 9) % 16);
        sidx++;
        case (mode)
            1:       rxv = d2 ^ 4'b0100;
            2:       rxv = ~d2;
            default: rxv = d2;
        endcase
        {ref_i_sym, ref_q_sym} = refv;
        {rx_i_sym, rx_q_sym}   = rxv;
        sam_clk_ena = 1'b1;
        @(posedge clk); #1;
        sam_clk_ena = 1'b0;
        d2 = d1;
        d1 = refv;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_load_hi"}, 32'(load_data), 1);
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_done_lo"}, 32'(done), 0);
        check({tag, "_cnt_clr"}, 32'(sym_count), 0);
        check({tag, "_berr_clr"}, 32'(bit_err_count), 0);
        @(posedge clk); #1;
        check({tag, "_load_lo"}, 32'(load_data), 0);
    endtask

    // 3 flush + 16 measure strobes; optional start pulse part-way must be ignored.
    task automatic run_measure(input string tag, input int mode, input int exp_se,
                               input int exp_be, input bit poke_start);
        for (int k = 0; k < 18; k++) begin
            strobe(mode);
            if (poke_start && k == 7) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                check({tag, "_start_ign_busy"}, 32'(busy), 1);
                check({tag, "_start_ign_load"}, 32'(load_data), 0);
            end
        end
        check({tag, "_done_early"}, 32'(done), 0);
        check({tag, "_cnt15"}, 32'(sym_count), 15);
        strobe(mode);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_lo"}, 32'(busy), 0);
        check({tag, "_sym_count"}, 32'(sym_count), 16);
        check({tag, "_sym_err"}, 32'(sym_err_count), 32'(exp_se));
        check({tag, "_bit_err"}, 32'(bit_err_count), 32'(exp_be));
    endtask

    initial begin
        reset = 1'b1;
        sam_clk_ena = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ref_i_sym = '0; ref_q_sym = '0; rx_i_sym = '0; rx_q_sym = '0;
        d1 = '0; d2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_load", 32'(load_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sym", 32'(sym_count), 0);
        check("rst_serr", 32'(sym_err_count), 0);
        check("rst_berr", 32'(bit_err_count), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        start_run("r1");
        run_measure("r1", 0, 0, 0, 1'b0);
        strobe(0);
        check("frozen_sym", 32'(sym_count), 16);
        check("frozen_done", 32'(done), 1);

        start_run("r2");
        run_measure("r2", 1, 16, 16, 1'b1);

        start_run("r3");
        run_measure("r3", 2, 16, 64, 1'b0);

        start_run("ab");
        repeat (11) strobe(0);
        check("ab_pre_busy", 32'(busy), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_done", 32'(done), 0);
        check("ab_sym", 32'(sym_count), 8);
        strobe(0);
        check("ab_held", 32'(sym_count), 8);

        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("sa_load", 32'(load_data), 0);
        check("sa_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("sa_busy2", 32'(busy), 0);

        start_run("rs");
        repeat (7) strobe(0);
        check("rs_pre_sym", 32'(sym_count), 4);
        #2;
        reset = 1'b1;
        #1;
        check("rs_sym", 32'(sym_count), 0);
        check("rs_busy", 32'(busy), 0);
        check("rs_load", 32'(load_data), 0);
        check("rs_done", 32'(done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        d1 = '0;
        d2 = '0;
        @(posedge clk); #1;

        start_run("r4");
        run_measure("r4", 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
